iir_out_peak_meter: RTL and testbench
=====================================

# iir_out_peak_meter

Hardware sink for the bandstop IIR filter output stream. It consumes the filter's signed Q16.12 output samples, discards a programmable settling interval, then measures peak-to-peak amplitude over a fixed window. It reports min, max, peak-to-peak and a pass/fail flag against a rejection threshold. It sits directly downstream of `chebyshev_bs_iir` and enables on-chip notch-attenuation checks without a simulator monitor.

## Interface
- `WL`, 28: sample word length, two's complement, Q(WL-12).12
- `SETTLE`, 60: valid samples discarded after start (filter transient)
- `WIN`, 60: valid samples measured (10 periods of 60 Hz at 360 Hz)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a measurement
- `abort`  in  1  cancel the measurement in progress
- `y_valid`  in  1  `y_in` carries a new filter sample this cycle
- `y_in`  in  WL  signed filter output sample
- `thresh`  in  WL+1  unsigned peak-to-peak limit, same LSB weight as `y_in`
- `busy`  out  1  measurement in progress (SETTLE or MEASURE)
- `done`  out  1  one-cycle pulse when results update
- `y_max`  out  WL  signed maximum over the window
- `y_min`  out  WL  signed minimum over the window
- `pkpk`  out  WL+1  unsigned `y_max - y_min`
- `pass`  out  1  `pkpk <= thresh`

## Operation
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: `start`=1 → SETTLE, and the sample counter clears to 0. `start` is ignored in every other state.
- SETTLE: each `y_valid` increments the counter. When the SETTLE-th valid sample is accepted → MEASURE, the counter clears, and the trackers load max=−2^(WL−1), min=2^(WL−1)−1. If SETTLE=0, IDLE goes straight to MEASURE.
- MEASURE: each `y_valid` updates max/min with `y_in`, using signed compares, and increments the counter. When the WIN-th valid sample is accepted (that sample is included) → DONE.
- DONE: registers `y_max`, `y_min`, `pkpk` = sign-extended max − min computed in WL+1 bits (always ≥0), and `pass`. Asserts `done`, then → IDLE.
- Cycles without `y_valid` do not advance SETTLE or MEASURE.
- `abort`=1 in SETTLE or MEASURE → IDLE on the next edge. No `done`; result outputs keep their previous values. `abort` has priority over sample acceptance in the same cycle. `abort` in IDLE or DONE is ignored.
- Counter width is ceil(log2(max(SETTLE,WIN)+1)).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `y_max`=0, `y_min`=0, `pkpk`=0, `pass`=0, counter=0, trackers=0.
- `busy` is registered. It goes high on the edge that samples `start` and goes low on the edge that enters DONE.
- `done` is high for exactly one cycle: the cycle following the edge that accepted the last MEASURE sample. The result outputs change on that same edge and hold until the next DONE.
- Minimum start-to-done latency with `y_valid` held high: SETTLE+WIN+1 cycles.
- `start` asserted in the DONE cycle is ignored. The earliest accepted restart is the cycle after `done`.
- Reset deassertion mid-measurement is treated as a fresh power-up. No partial results are reported.

## Structure
- Shared package/header `iir_meter_pkg` holds:
  - the state encoding (IDLE=0, SETTLE=1, MEASURE=2, DONE=3)
  - default `WL`=28 and fraction width 12
  - the min/max init constants, shared with `chebyshev_bs_iir` benches
- One sub-module, `minmax_track`:
  - ports: `clk`, `reset`, `init`, `en`, `d`, `max`, `min`
  - signed compare-and-update, one register each for max and min
- The FSM, counter and result registers live in the top module.

## Test plan
- Constant `y_in`=0, `y_valid`=1, `thresh`=409600 (100.0) → `done` at cycle 121 after start; `y_max`=`y_min`=0, `pkpk`=0, `pass`=1.
- Repeating 6-sample sequence 0, 3192516, 3192516, 0, −3192516, −3192516 (±779.423) → `y_max`=3192516, `y_min`=−3192516, `pkpk`=6385032, `pass`=0 with `thresh`=409600; `pass`=1 with `thresh`=6385032.
- `y_valid` toggling every other cycle → `done` at cycle 2·120+1 after start; results identical to the continuous case.
- Extremes `y_in`=−2^27 and 2^27−1 inside the window → `pkpk`=2^28−1, with no overflow in WL+1 bits.
- `start` pulsed again during MEASURE, then `abort` at sample 30 of a second run → the first `start` is ignored; abort gives no `done`, `busy` falls next cycle, and the old results are held.
- `reset` low mid-MEASURE → all outputs are 0 immediately (asynchronous); after release, a fresh start completes normally.

Source files
------------

// File: rtl/iir_meter_pkg.sv
// Shared definitions for the IIR output peak meter: FSM encoding, default word
// length and the min/max tracker start values.
package iir_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int WL_DEF = 28;
  localparam int FRAC_W = 12;

  // Trackers start at the opposite extremes so the first sample always wins.
  localparam logic signed [WL_DEF-1:0] TRK_MAX_INIT = {1'b1, {(WL_DEF-1){1'b0}}};
  localparam logic signed [WL_DEF-1:0] TRK_MIN_INIT = {1'b0, {(WL_DEF-1){1'b1}}};

endpackage

// File: rtl/iir_out_peak_meter_minmax_track.sv
// Signed running maximum/minimum tracker; init loads the extreme start values,
// en folds the current sample into both registers.
module minmax_track
  import iir_meter_pkg::*;
#(
  parameter int WL = WL_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 en,
  input  logic signed [WL-1:0] d,
  output logic signed [WL-1:0] max,
  output logic signed [WL-1:0] min
);

  localparam logic signed [WL-1:0] MAX_INIT = {1'b1, {(WL-1){1'b0}}};
  localparam logic signed [WL-1:0] MIN_INIT = {1'b0, {(WL-1){1'b1}}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max <= '0;
      min <= '0;
    end else if (init) begin
      max <= MAX_INIT;
      min <= MIN_INIT;
    end else if (en) begin
      if (d > max) max <= d;
      if (d < min) min <= d;
    end
  end

endmodule

// File: rtl/iir_out_peak_meter.sv
// Peak-to-peak meter for the bandstop IIR output: skips SETTLE samples, then
// tracks min/max over WIN samples and reports pkpk and a threshold pass flag.
//
//   state   | meaning
//   IDLE    | waiting for start
//   SETTLE  | discarding filter transient samples
//   MEASURE | tracking min/max over the window
//   DONE    | one-cycle result pulse, back to IDLE
module iir_out_peak_meter
  import iir_meter_pkg::*;
#(
  parameter int WL     = WL_DEF,
  parameter int SETTLE = 60,
  parameter int WIN    = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 y_valid,
  input  logic signed [WL-1:0] y_in,
  input  logic        [WL:0]   thresh,
  output logic                 busy,
  output logic                 done,
  output logic signed [WL-1:0] y_max,
  output logic signed [WL-1:0] y_min,
  output logic        [WL:0]   pkpk,
  output logic                 pass
);

  localparam int CNT_MAX = (SETTLE > WIN) ? SETTLE : WIN;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN - 1);

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic trk_init, trk_en, res_load;
  logic signed [WL-1:0] trk_max, trk_min, fin_max, fin_min;
  logic [WL:0] pkpk_calc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = (SETTLE == 0) ? ST_MEASURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (y_valid) begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = ST_MEASURE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (y_valid) begin
          if (cnt == WIN_LAST) begin
            state_nxt = ST_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_SETTLE) || (state == ST_MEASURE);
    done     = (state == ST_DONE);
    trk_init = (state_nxt == ST_MEASURE) && (state != ST_MEASURE);
    trk_en   = (state == ST_MEASURE) && y_valid && !abort;
    res_load = trk_en && (cnt == WIN_LAST);
  end

  minmax_track #(.WL(WL)) u_track (
    .clk   (clk),
    .reset (reset),
    .init  (trk_init),
    .en    (trk_en),
    .d     (y_in),
    .max   (trk_max),
    .min   (trk_min)
  );

  // Results load on the edge that accepts the last sample, so that sample is
  // folded in here rather than waiting a cycle for the trackers.
  assign fin_max   = (y_in > trk_max) ? y_in : trk_max;
  assign fin_min   = (y_in < trk_min) ? y_in : trk_min;
  assign pkpk_calc = {fin_max[WL-1], fin_max} - {fin_min[WL-1], fin_min};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_max <= '0;
      y_min <= '0;
      pkpk  <= '0;
      pass  <= 1'b0;
    end else if (res_load) begin
      y_max <= fin_max;
      y_min <= fin_min;
      pkpk  <= pkpk_calc;
      pass  <= (pkpk_calc <= thresh);
    end
  end

endmodule

// File: tb/tb_iir_out_peak_meter.sv
// Scoreboard bench for iir_out_peak_meter: runs push expected results, a
// monitor pops and compares on every done pulse.
module tb_iir_out_peak_meter;
  import iir_meter_pkg::*;

  localparam int WL = WL_DEF;

  typedef struct {
    logic signed [WL-1:0] mx;
    logic signed [WL-1:0] mn;
    logic        [WL:0]   pp;
    logic                 ps;
    int                   lat;
  } exp_t;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, y_valid = 1'b0;
  logic signed [WL-1:0] y_in = '0;
  logic        [WL:0]   thresh = '0;
  logic busy, done, pass;
  logic signed [WL-1:0] y_max, y_min;
  logic        [WL:0]   pkpk;

  int checks = 0, failures = 0, cyc = 0, start_cyc = 0;
  exp_t sb[$];
  logic signed [WL-1:0] stim[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_out_peak_meter dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .y_valid (y_valid),
    .y_in    (y_in),
    .thresh  (thresh),
    .busy    (busy),
    .done    (done),
    .y_max   (y_max),
    .y_min   (y_min),
    .pkpk    (pkpk),
    .pass    (pass)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("y_max", longint'(y_max), longint'(e.mx));
        chk("y_min", longint'(y_min), longint'(e.mn));
        chk("pkpk", longint'(pkpk), longint'(e.pp));
        chk("pass", longint'(pass), longint'(e.ps));
        chk("latency", longint'(cyc - start_cyc), longint'(e.lat));
      end
    end
  end

  task automatic run(input bit tog, input logic [WL:0] th, input bit push, input exp_t e,
                     input int again_at, input int abort_at, input int rst_at,
                     input bit done_start);
    int k = 0;
    int sidx = 0;
    @(negedge clk);
    thresh = th; start = 1'b1; y_valid = 1'b0; start_cyc = cyc;
    if (push) sb.push_back(e);
    while (sidx < 120 && k < 400) begin
      @(negedge clk);
      k++;
      start   = (sidx == again_at);
      y_valid = tog ? (k % 2 == 0) : 1'b1;
      y_in    = y_valid ? stim[sidx % stim.size()] : '0;
      if (y_valid && sidx == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; y_valid = 1'b0; start = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        return;
      end
      if (y_valid && sidx == rst_at) begin
        reset = 1'b0;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_y_max", longint'(y_max), 0);
        chk("rst_y_min", longint'(y_min), 0);
        chk("rst_pkpk", longint'(pkpk), 0);
        chk("rst_pass", longint'(pass), 0);
        @(negedge clk);
        reset = 1'b1; y_valid = 1'b0; start = 1'b0;
        return;
      end
      if (y_valid) sidx++;
    end
    chk("feed_bound", longint'(sidx), 120);
    @(negedge clk);
    y_valid = 1'b0; start = done_start;
    @(negedge clk);
    start = 1'b0;
    if (done_start) chk("done_cycle_start_busy", longint'(busy), 0);
    @(negedge clk);
    chk("sb_drained", longint'(sb.size()), 0);
  endtask

  task automatic set_zeros();
    stim.delete();
    stim.push_back('0);
  endtask

  task automatic set_sine();
    stim.delete();
    stim.push_back(28'sd0);
    stim.push_back(28'sd3192516);
    stim.push_back(28'sd3192516);
    stim.push_back(28'sd0);
    stim.push_back(-28'sd3192516);
    stim.push_back(-28'sd3192516);
  endtask

  task automatic set_sparse(input int i0, input logic signed [WL-1:0] v0,
                            input int i1, input logic signed [WL-1:0] v1);
    stim.delete();
    for (int i = 0; i < 120; i++) stim.push_back('0);
    stim[i0] = v0;
    stim[i1] = v1;
  endtask

  initial begin
    #2;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_y_max", longint'(y_max), 0);
    chk("reset_y_min", longint'(y_min), 0);
    chk("reset_pkpk", longint'(pkpk), 0);
    chk("reset_pass", longint'(pass), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    set_zeros();
    run(1'b0, 29'd409600, 1'b1, '{28'sd0, 28'sd0, 29'd0, 1'b1, 121}, -1, -1, -1, 1'b1);

    set_sine();
    run(1'b0, 29'd409600, 1'b1,
        '{28'sd3192516, -28'sd3192516, 29'd6385032, 1'b0, 121}, -1, -1, -1, 1'b0);
    run(1'b0, 29'd6385032, 1'b1,
        '{28'sd3192516, -28'sd3192516, 29'd6385032, 1'b1, 121}, -1, -1, -1, 1'b0);

    set_zeros();
    run(1'b1, 29'd409600, 1'b1, '{28'sd0, 28'sd0, 29'd0, 1'b1, 241}, -1, -1, -1, 1'b0);

    set_sparse(60, TRK_MAX_INIT, 119, TRK_MIN_INIT);
    run(1'b0, 29'd409600, 1'b1,
        '{TRK_MIN_INIT, TRK_MAX_INIT, 29'd268435455, 1'b0, 121}, -1, -1, -1, 1'b0);

    set_sparse(0, -28'sd4096000, 59, 28'sd4096000);
    run(1'b0, 29'd409600, 1'b1, '{28'sd0, 28'sd0, 29'd0, 1'b1, 121}, -1, -1, -1, 1'b0);

    // Restart pulse mid-window is ignored; then a second run is aborted.
    set_sine();
    run(1'b0, 29'd6385032, 1'b1,
        '{28'sd3192516, -28'sd3192516, 29'd6385032, 1'b1, 121}, 70, -1, -1, 1'b0);
    run(1'b0, 29'd6385032, 1'b0, '{28'sd0, 28'sd0, 29'd0, 1'b0, 0}, -1, 90, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_hold_y_max", longint'(y_max), 3192516);
    chk("abort_hold_y_min", longint'(y_min), -3192516);
    chk("abort_hold_pkpk", longint'(pkpk), 6385032);
    chk("abort_hold_pass", longint'(pass), 1);
    chk("abort_no_result", longint'(sb.size()), 0);

    set_zeros();
    run(1'b0, 29'd409600, 1'b0, '{28'sd0, 28'sd0, 29'd0, 1'b0, 0}, -1, -1, 80, 1'b0);
    repeat (2) @(negedge clk);
    chk("post_rst_busy", longint'(busy), 0);
    run(1'b0, 29'd409600, 1'b1, '{28'sd0, 28'sd0, 29'd0, 1'b1, 121}, -1, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
